cache_ctrl_2way: RTL

Controller for the board's 2-way set-associative cache in front of the byte-wide RAM.
- Accepts one CPU-side read/write at a time and resolves it as a hit or a miss.
- Performs write-back of a dirty victim, line fill from RAM, and LRU replacement.
- Reports data, hit flag and way to the top level for HEX/LED display.
- Holds the tag/valid/dirty/LRU/data arrays internally. Sequences the external RAM over a req/ack handshake.

---
 rtl/cache_pkg.sv | 22 ++
 rtl/cache_way_array.sv | 62 ++++++
 rtl/cache_ctrl_2way.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the 2-way set-associative cache controller.
package cache_pkg;

    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned IDX_W_DEF  = 2;
    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned CNT_W_DEF  = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_WRITEBACK,
        ST_FILL,
        ST_RESPOND
    } state_e;

    // Tag bits are whatever remains of the address above the set index.
    function automatic int unsigned tag_width(input int unsigned addr_w, input int unsigned idx_w);
        return addr_w - idx_w;
    endfunction

endpackage

// File: rtl/cache_way_array.sv
// One cache way: per-set tag/valid/dirty/data with a synchronous write port
// and a combinational read port sharing the same set index.
module cache_way_array #(
    parameter int unsigned IDX_W  = 2,
    parameter int unsigned TAG_W  = 3,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [IDX_W-1:0]  idx,
    output logic              rd_valid,
    output logic              rd_dirty,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic              wr_dirty,
    input  logic [DATA_W-1:0] wr_data
);

    localparam int unsigned SETS = 1 << IDX_W;

    logic [SETS-1:0]   valid_q, valid_d;
    logic [SETS-1:0]   dirty_q, dirty_d;
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [TAG_W-1:0]  tag_d  [SETS];
    logic [DATA_W-1:0] data_q [SETS];
    logic [DATA_W-1:0] data_d [SETS];

    assign rd_valid = valid_q[idx];
    assign rd_dirty = dirty_q[idx];
    assign rd_tag   = tag_q[idx];
    assign rd_data  = data_q[idx];

    // Any write marks the entry valid; tag and dirty come from the caller.
    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (wr_en) begin
            valid_d[idx] = 1'b1;
            dirty_d[idx] = wr_dirty;
            tag_d[idx]   = wr_tag;
            data_d[idx]  = wr_data;
        end
    end

    // Only valid/dirty are reset; tag and data are don't-care until valid.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
        tag_q  <= tag_d;
        data_q <= data_d;
    end

endmodule

// File: rtl/cache_ctrl_2way.sv
// 2-way set-associative cache controller: hit/miss resolution, dirty
// write-back, line fill over a req/ack RAM handshake, LRU and statistics.
module cache_ctrl_2way
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned IDX_W  = IDX_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_done,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_hit,
    output logic              cpu_way,
    output logic              busy,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);

    localparam int unsigned TAG_W = tag_width(ADDR_W, IDX_W);
    localparam int unsigned SETS  = 1 << IDX_W;

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              victim_q, victim_d;
    logic [SETS-1:0]   lru_q, lru_d;
    logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              hit_q, hit_d;
    logic              way_q, way_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic [1:0]        rd_valid, rd_dirty, wr_en;
    logic [TAG_W-1:0]  rd_tag  [2];
    logic [DATA_W-1:0] rd_data [2];
    logic              wr_dirty;
    logic [DATA_W-1:0] wr_data;
    logic              hit0, hit1, hit_any, hit_way, victim_sel;

    assign idx = addr_q[IDX_W-1:0];
    assign tag = addr_q[ADDR_W-1:IDX_W];

    for (genvar w = 0; w < 2; w++) begin : g_way
        cache_way_array #(
            .IDX_W  (IDX_W),
            .TAG_W  (TAG_W),
            .DATA_W (DATA_W)
        ) u_way (
            .clock    (clock),
            .reset    (reset),
            .idx      (idx),
            .rd_valid (rd_valid[w]),
            .rd_dirty (rd_dirty[w]),
            .rd_tag   (rd_tag[w]),
            .rd_data  (rd_data[w]),
            .wr_en    (wr_en[w]),
            .wr_tag   (tag),
            .wr_dirty (wr_dirty),
            .wr_data  (wr_data)
        );
    end

    // Way 0 wins a (theoretically impossible) double match.
    assign hit0       = rd_valid[0] && (rd_tag[0] == tag);
    assign hit1       = rd_valid[1] && (rd_tag[1] == tag);
    assign hit_any    = hit0 || hit1;
    assign hit_way    = !hit0;
    assign victim_sel = !rd_valid[0] ? 1'b0 : (!rd_valid[1] ? 1'b1 : lru_q[idx]);

    // Next-state, array write and registered-output computation.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        victim_d    = victim_q;
        lru_d       = lru_q;
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        done_d      = 1'b0;
        rdata_d     = rdata_q;
        hit_d       = hit_q;
        way_d       = way_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        wr_en       = '0;
        wr_dirty    = 1'b0;
        wr_data     = '0;
        case (state_q)
            ST_IDLE: begin
                if (cpu_req) begin
                    we_d    = cpu_we;
                    addr_d  = cpu_addr;
                    wdata_d = cpu_wdata;
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (hit_any) begin
                    if (we_q) begin
                        wr_en[hit_way] = 1'b1;
                        wr_dirty       = 1'b1;
                        wr_data        = wdata_q;
                        rdata_d        = wdata_q;
                    end else begin
                        rdata_d = rd_data[hit_way];
                    end
                    lru_d[idx] = ~hit_way;
                    hit_cnt_d  = hit_cnt_q + 1'b1;
                    hit_d      = 1'b1;
                    way_d      = hit_way;
                    done_d     = 1'b1;
                    state_d    = ST_RESPOND;
                end else begin
                    miss_cnt_d = miss_cnt_q + 1'b1;
                    victim_d   = victim_sel;
                    mem_req_d  = 1'b1;
                    if (rd_valid[victim_sel] && rd_dirty[victim_sel]) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = {rd_tag[victim_sel], idx};
                        mem_wdata_d = rd_data[victim_sel];
                        state_d     = ST_WRITEBACK;
                    end else begin
                        mem_we_d    = 1'b0;
                        mem_addr_d  = addr_q;
                        mem_wdata_d = '0;
                        state_d     = ST_FILL;
                    end
                end
            end
            ST_WRITEBACK: begin
                if (mem_ack) begin
                    mem_we_d    = 1'b0;
                    mem_addr_d  = addr_q;
                    mem_wdata_d = '0;
                    state_d     = ST_FILL;
                end
            end
            ST_FILL: begin
                if (mem_ack) begin
                    wr_en[victim_q] = 1'b1;
                    wr_dirty        = we_q;
                    wr_data         = we_q ? wdata_q : mem_rdata;
                    rdata_d         = wr_data;
                    lru_d[idx]      = ~victim_q;
                    hit_d           = 1'b0;
                    way_d           = victim_q;
                    mem_req_d       = 1'b0;
                    done_d          = 1'b1;
                    state_d         = ST_RESPOND;
                end
            end
            ST_RESPOND: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Controller state and registered outputs; reset overrides everything.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            victim_q    <= 1'b0;
            lru_q       <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
            done_q      <= 1'b0;
            rdata_q     <= '0;
            hit_q       <= 1'b0;
            way_q       <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            victim_q    <= victim_d;
            lru_q       <= lru_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            done_q      <= done_d;
            rdata_q     <= rdata_d;
            hit_q       <= hit_d;
            way_q       <= way_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign cpu_done  = done_q;
    assign cpu_rdata = rdata_q;
    assign cpu_hit   = hit_q;
    assign cpu_way   = way_q;
    assign busy      = (state_q != ST_IDLE);
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign hit_cnt   = hit_cnt_q;
    assign miss_cnt  = miss_cnt_q;

endmodule
